// File: rtl/vtc_cfg.sv
// Video timing controller with double-buffered runtime configuration; outputs registered one cycle after counter state.
// New timing lands only at frame end (or while stopped); bad strobes are dropped and flagged with cfg_err.
module vtc_cfg #(
  parameter int CNT_W        = 12,
  parameter int DEF_H_ACTIVE = 1280,
  parameter int DEF_H_FP     = 110,
  parameter int DEF_H_SYNC   = 40,
  parameter int DEF_H_BP     = 220,
  parameter int DEF_V_ACTIVE = 720,
  parameter int DEF_V_FP     = 5,
  parameter int DEF_V_SYNC   = 5,
  parameter int DEF_V_BP     = 20,
  parameter bit DEF_HPOL     = 1'b0,
  parameter bit DEF_VPOL     = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_hpol,
  input  logic             cfg_vpol,
  input  logic             cfg_valid,
  output logic             cfg_err,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof
);

  localparam int CW = CNT_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic             hpol;
    logic             vpol;
  } timing_t;

  localparam timing_t DEF_SET = '{
    h_active: CNT_W'(DEF_H_ACTIVE), h_fp: CNT_W'(DEF_H_FP),
    h_sync:   CNT_W'(DEF_H_SYNC),   h_bp: CNT_W'(DEF_H_BP),
    v_active: CNT_W'(DEF_V_ACTIVE), v_fp: CNT_W'(DEF_V_FP),
    v_sync:   CNT_W'(DEF_V_SYNC),   v_bp: CNT_W'(DEF_V_BP),
    hpol:     DEF_HPOL,             vpol: DEF_VPOL
  };

  timing_t         cfg_set, pend, act;
  logic            pend_flag;
  logic [CW-1:0]   cnt_h, cnt_v;
  logic [CW-1:0]   h_start, h_end, h_tot, v_start, v_end, v_tot;
  logic            h_last, v_last, apply, cfg_ok;
  logic            de_c;

  always_comb begin
    cfg_set = '{
      h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
      v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
      hpol: cfg_hpol, vpol: cfg_vpol
    };
  end

  // Extra counter bits keep the sum of four CNT_W fields from overflowing.
  assign h_start = CW'(act.h_sync) + CW'(act.h_bp);
  assign h_end   = h_start + CW'(act.h_active);
  assign h_tot   = h_end + CW'(act.h_fp);
  assign v_start = CW'(act.v_sync) + CW'(act.v_bp);
  assign v_end   = v_start + CW'(act.v_active);
  assign v_tot   = v_end + CW'(act.v_fp);

  assign h_last = (cnt_h >= h_tot - CW'(1));
  assign v_last = (cnt_v >= v_tot - CW'(1));
  assign apply  = !en || (h_last && v_last);
  assign cfg_ok = cfg_valid && (cfg_h_active != '0) && (cfg_h_sync != '0) &&
                  (cfg_v_active != '0) && (cfg_v_sync != '0);
  assign de_c   = (cnt_h >= h_start) && (cnt_h < h_end) &&
                  (cnt_v >= v_start) && (cnt_v < v_end);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend      <= DEF_SET;
      act       <= DEF_SET;
      pend_flag <= 1'b0;
      cnt_h     <= '0;
      cnt_v     <= '0;
      cfg_err   <= 1'b0;
      hsync     <= ~DEF_HPOL;
      vsync     <= ~DEF_VPOL;
      de        <= 1'b0;
      x         <= '0;
      y         <= '0;
      sof       <= 1'b0;
    end else begin
      if (cfg_ok) pend <= cfg_set;

      // A strobe landing on the application point bypasses the pending set.
      if (apply) begin
        if (cfg_ok)         act <= cfg_set;
        else if (pend_flag) act <= pend;
        pend_flag <= 1'b0;
      end else if (cfg_ok) begin
        pend_flag <= 1'b1;
      end

      if (!en) begin
        cnt_h <= '0;
        cnt_v <= '0;
      end else if (h_last) begin
        cnt_h <= '0;
        cnt_v <= v_last ? '0 : cnt_v + CW'(1);
      end else begin
        cnt_h <= cnt_h + CW'(1);
      end

      cfg_err <= cfg_valid && !cfg_ok;

      if (!en) begin
        hsync <= ~act.hpol;
        vsync <= ~act.vpol;
        de    <= 1'b0;
        x     <= '0;
        y     <= '0;
        sof   <= 1'b0;
      end else begin
        hsync <= (cnt_h < CW'(act.h_sync)) ? act.hpol : ~act.hpol;
        vsync <= (cnt_v < CW'(act.v_sync)) ? act.vpol : ~act.vpol;
        de    <= de_c;
        x     <= de_c ? CNT_W'(cnt_h - h_start) : '0;
        y     <= de_c ? CNT_W'(cnt_v - v_start) : '0;
        sof   <= (cnt_h == '0) && (cnt_v == '0);
      end
    end
  end

endmodule

// File: doc/vtc_cfg.md
VTC_CFG -- requirements
Module: vtc_cfg

Interface
REQ-001 SHALL have parameter CNT_W, default 12, meaning width of every timing field, counter and coordinate.
REQ-002 SHALL have parameter DEF_H_ACTIVE/DEF_H_FP/DEF_H_SYNC/DEF_H_BP, defaults 1280/110/40/220, meaning reset horizontal timing.
REQ-003 SHALL have parameter DEF_V_ACTIVE/DEF_V_FP/DEF_V_SYNC/DEF_V_BP, defaults 720/5/5/20, meaning reset vertical timing.
REQ-004 SHALL have parameter DEF_HPOL/DEF_VPOL, default 0/0, meaning reset sync polarity (active level).
REQ-005 clk  input  1  pixel clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  timing run enable.
REQ-008 cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  input  CNT_W each  requested horizontal timing.
REQ-009 cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  input  CNT_W each  requested vertical timing.
REQ-010 cfg_hpol, cfg_vpol  input  1 each  requested sync polarity.
REQ-011 cfg_valid  input  1  single-cycle strobe capturing all cfg_* inputs.
REQ-012 cfg_err  output  1  one-cycle pulse: strobed config rejected.
REQ-013 hsync, vsync  output  1 each  sync outputs.
REQ-014 de  output  1  active-video data enable.
REQ-015 x, y  output  CNT_W each  active pixel coordinate; 0 outside active.
REQ-016 sof  output  1  one-cycle start-of-frame pulse.

Function
REQ-017 Timing SHALL use three register sets: pending (written by cfg_valid), active (drives counters), counters cnt_h/cnt_v (CNT_W+2 bits); H_TOTAL = sync+bp+active+fp, same for V.
REQ-018 Line/frame order SHALL be sync, back porch, active, front porch; cnt_h wraps at H_TOTAL-1, cnt_v increments on cnt_h wrap and wraps at V_TOTAL-1.
REQ-019 cfg_valid with any of h_active, h_sync, v_active, v_sync equal to 0 SHALL be rejected: pending unchanged, cfg_err=1 next cycle; porches may be 0.
REQ-020 Accepted cfg_valid SHALL write pending and set a pending-flag; later cfg_valid before application overwrites pending (last wins).
REQ-021 Pending SHALL copy to active at the cycle where cnt_h==H_TOTAL-1 and cnt_v==V_TOTAL-1 with en=1, or any cycle with en=0; flag then clears.
REQ-022 cfg_valid accepted in the same cycle as an application point SHALL apply its own values directly (bypass).
REQ-023 All outputs SHALL be registered, 1 cycle after the counter state they decode.
REQ-024 hsync SHALL equal hpol when cnt_h < h_sync, else ~hpol; vsync likewise with cnt_v, v_sync, vpol.
REQ-025 de SHALL be 1 when h_sync+h_bp <= cnt_h < h_sync+h_bp+h_active and v_sync+v_bp <= cnt_v < v_sync+v_bp+v_active.
REQ-026 x = cnt_h-(h_sync+h_bp), y = cnt_v-(v_sync+v_bp) when de condition true, else 0.
REQ-027 sof SHALL be 1 for the output cycle decoding cnt_h==0, cnt_v==0 with en=1.
REQ-028 en=0 SHALL force cnt_h=cnt_v=0 and outputs idle (hsync=~hpol, vsync=~vpol, de=0, x=y=0, sof=0) next cycle; en rising restarts from cnt 0,0 with sof.
REQ-029 Polarity changes SHALL take effect only with the active-set copy, never mid-frame.

Reset
REQ-030 rstn=0 SHALL load pending and active sets from DEF_* parameters, clear pending-flag, counters 0, hsync=~DEF_HPOL, vsync=~DEF_VPOL, de=0, x=y=0, sof=0, cfg_err=0.
REQ-031 rstn=0 mid-frame SHALL discard any unapplied pending config.

Verification
REQ-032 Small timing h 4/1/2/1 (total 8), v 3/1/1/1 (total 6) applied with en=0 then en=1 -> sof on first output cycle; hsync low 2 cycles per 8; de high cnt_h 3..6 on lines 2..4; x 0..3, y 0..2; frame period 48 cycles.
REQ-033 Mid-frame cfg_valid changing h_active 4->2 -> current frame unchanged; next frame de 2 cycles per line, period 36.
REQ-034 cfg_valid with v_sync=0 -> cfg_err pulse 1 cycle, timing unchanged over 2 frames.
REQ-035 cfg_valid on last cycle of frame with hpol=1 -> next frame hsync high-active immediately.
REQ-036 rstn pulse mid-frame after pending write -> outputs idle one cycle, then DEF 1280x720 timing: hsync low 40 of 1650 cycles, frame 1650x750.
